// File: rtl/ysyx_24100006_arch_state.sv
// rtl/ysyx_24100006_arch_state.sv - architectural state: GPR file, M-mode CSRs, operand holding registers
//
// Purpose:
//   Holds the architectural state of the ysyx_24100006 multi-cycle RV32 core.
//   It sits between the decode/controller and the ALU/NPC logic.
//
// Ports:
//   i_clk, i_reset                      clock, asynchronous active-high reset
//   i_gpr_wen/i_gpr_waddr/i_gpr_wdata   GPR write port (writes to x0 dropped)
//   i_rs1, i_rs2                        GPR read indices
//   o_rs1_data_raw, o_rs2_data_raw      combinational GPR reads
//   i_opnd_wen                          load enable for the operand holding registers
//   o_rs1_data, o_rs2_data              registered operand copies (1-cycle latency)
//   i_csr_wen/i_csr_waddr/i_csr_wdata   CSR write port (i_csr_wdata carries the PC on a trap)
//   i_csr_raddr, o_csr_rdata            combinational CSR read port
//   i_irq, i_irq_no                     trap-entry request and cause code
//   o_mtvec, o_mepc                     continuous views for next-PC selection
//
// Optional feature macro: YSYX_CSR_ID_EN adds read-only mvendorid (0xF11) and
// marchid (0xF12); without it those addresses read as zero like any unmapped CSR.

module ysyx_24100006_arch_state #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_gpr_wen,
    input  logic [AW-1:0]   i_gpr_waddr,
    input  logic [XLEN-1:0] i_gpr_wdata,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    output logic [XLEN-1:0] o_rs1_data_raw,
    output logic [XLEN-1:0] o_rs2_data_raw,
    input  logic            i_opnd_wen,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_csr_wen,
    input  logic [11:0]     i_csr_waddr,
    input  logic [XLEN-1:0] i_csr_wdata,
    input  logic [11:0]     i_csr_raddr,
    output logic [XLEN-1:0] o_csr_rdata,
    input  logic            i_irq,
    input  logic [7:0]      i_irq_no,
    output logic [XLEN-1:0] o_mtvec,
    output logic [XLEN-1:0] o_mepc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`ifdef YSYX_CSR_ID_EN
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [XLEN-1:0] MVENDORID_VAL = XLEN'(32'h7973_7978);
    localparam logic [XLEN-1:0] MARCHID_VAL   = XLEN'(32'h016F_BCA6);
`endif
    localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800);

    logic [XLEN-1:0] r_gpr [NREG];
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] w_rs1_raw;
    logic [XLEN-1:0] w_rs2_raw;
    logic [XLEN-1:0] w_csr_rdata;

    // GPR file: x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (i_gpr_wen && (i_gpr_waddr != '0)) begin
            r_gpr[i_gpr_waddr] <= i_gpr_wdata;
        end
    end

    // Reads see only committed state; a write in flight is visible after the edge.
    assign w_rs1_raw = (i_rs1 == '0) ? '0 : r_gpr[i_rs1];
    assign w_rs2_raw = (i_rs2 == '0) ? '0 : r_gpr[i_rs2];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (i_opnd_wen) begin
            r_rs1_data <= w_rs1_raw;
            r_rs2_data <= w_rs2_raw;
        end
    end

    // Trap entry wins over a same-cycle CSR write, which is then dropped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mstatus <= MSTATUS_RST;
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else if (i_irq) begin
            r_mepc   <= i_csr_wdata;
            r_mcause <= {{(XLEN-8){1'b0}}, i_irq_no};
        end else if (i_csr_wen) begin
            case (i_csr_waddr)
                CSR_MSTATUS: r_mstatus <= i_csr_wdata;
                CSR_MTVEC:   r_mtvec   <= i_csr_wdata;
                CSR_MEPC:    r_mepc    <= i_csr_wdata;
                CSR_MCAUSE:  r_mcause  <= i_csr_wdata;
                default:     ;
            endcase
        end
    end

    always_comb begin
        w_csr_rdata = '0;
        case (i_csr_raddr)
            CSR_MSTATUS:   w_csr_rdata = r_mstatus;
            CSR_MTVEC:     w_csr_rdata = r_mtvec;
            CSR_MEPC:      w_csr_rdata = r_mepc;
            CSR_MCAUSE:    w_csr_rdata = r_mcause;
`ifdef YSYX_CSR_ID_EN
            CSR_MVENDORID: w_csr_rdata = MVENDORID_VAL;
            CSR_MARCHID:   w_csr_rdata = MARCHID_VAL;
`endif
            default:       w_csr_rdata = '0;
        endcase
    end

    assign o_rs1_data_raw = w_rs1_raw;
    assign o_rs2_data_raw = w_rs2_raw;
    assign o_rs1_data     = r_rs1_data;
    assign o_rs2_data     = r_rs2_data;
    assign o_csr_rdata    = w_csr_rdata;
    assign o_mtvec        = r_mtvec;
    assign o_mepc         = r_mepc;

endmodule

// File: tb/tb_ysyx_24100006_arch_state.sv
// tb/tb_ysyx_24100006_arch_state.sv - scoreboard bench for ysyx_24100006_arch_state

module tb_ysyx_24100006_arch_state;

    logic        clk = 1'b0;
    logic        reset;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data_raw, rs2_data_raw, rs1_data, rs2_data;
    logic        opnd_wen;
    logic        csr_wen;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        irq;
    logic [7:0]  irq_no;
    logic [31:0] mtvec, mepc;

    always #5 clk = ~clk;

    ysyx_24100006_arch_state dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_gpr_wen      (gpr_wen),
        .i_gpr_waddr    (gpr_waddr),
        .i_gpr_wdata    (gpr_wdata),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .o_rs1_data_raw (rs1_data_raw),
        .o_rs2_data_raw (rs2_data_raw),
        .i_opnd_wen     (opnd_wen),
        .o_rs1_data     (rs1_data),
        .o_rs2_data     (rs2_data),
        .i_csr_wen      (csr_wen),
        .i_csr_waddr    (csr_waddr),
        .i_csr_wdata    (csr_wdata),
        .i_csr_raddr    (csr_raddr),
        .o_csr_rdata    (csr_rdata),
        .i_irq          (irq),
        .i_irq_no       (irq_no),
        .o_mtvec        (mtvec),
        .o_mepc         (mepc)
    );

    typedef struct {
        string       tag;
        logic [31:0] r1raw, r2raw, r1, r2, crd, tvec, epc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: plain arrays, CSRs keyed by address.
    logic [31:0] m_gpr [32];
    logic [31:0] m_csr [int];
    logic [31:0] m_op1, m_op2;

    function automatic logic [31:0] m_gread(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_gpr[a];
    endfunction

    function automatic logic [31:0] m_cread(input logic [11:0] a);
        if (m_csr.exists(int'(a))) return m_csr[int'(a)];
`ifdef YSYX_CSR_ID_EN
        if (a == 12'hF11) return 32'h7973_7978;
        if (a == 12'hF12) return 32'h016F_BCA6;
`endif
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_csr.delete();
        m_csr['h300] = 32'h0000_1800;
        m_csr['h305] = 32'd0;
        m_csr['h341] = 32'd0;
        m_csr['h342] = 32'd0;
        m_op1 = 32'd0;
        m_op2 = 32'd0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.r1raw = m_gread(rs1);
        e.r2raw = m_gread(rs2);
        e.r1    = m_op1;
        e.r2    = m_op2;
        e.crd   = m_cread(csr_raddr);
        e.tvec  = m_csr['h305];
        e.epc   = m_csr['h341];
        sb.push_back(e);
    endtask

    task automatic m_update();
        logic [31:0] a, b;
        a = m_gread(rs1);
        b = m_gread(rs2);
        if (opnd_wen) begin
            m_op1 = a;
            m_op2 = b;
        end
        if (gpr_wen && gpr_waddr != 5'd0) m_gpr[gpr_waddr] = gpr_wdata;
        if (irq) begin
            m_csr['h341] = csr_wdata;
            m_csr['h342] = {24'd0, irq_no};
        end else if (csr_wen && m_csr.exists(int'(csr_waddr))) begin
            m_csr[int'(csr_waddr)] = csr_wdata;
        end
    endtask

    // Inputs are set just after a rising edge; the monitor checks at the falling edge.
    task automatic step(input string tag);
        push_exp(tag);
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        gpr_wen = 0; gpr_waddr = 0; gpr_wdata = 0;
        opnd_wen = 0; csr_wen = 0; csr_waddr = 0; csr_wdata = 0;
        irq = 0; irq_no = 0;
    endtask

    function automatic logic [11:0] pick_csr();
        case ($urandom_range(0, 7))
            0: return 12'h300;
            1: return 12'h305;
            2: return 12'h341;
            3: return 12'h342;
            4: return 12'h7C0;
            5: return 12'hF11;
            6: return 12'hF12;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %h expected %h", tag, nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "rs1_data_raw", rs1_data_raw, e.r1raw);
            chk(e.tag, "rs2_data_raw", rs2_data_raw, e.r2raw);
            chk(e.tag, "rs1_data", rs1_data, e.r1);
            chk(e.tag, "rs2_data", rs2_data, e.r2);
            chk(e.tag, "csr_rdata", csr_rdata, e.crd);
            chk(e.tag, "mtvec", mtvec, e.tvec);
            chk(e.tag, "mepc", mepc, e.epc);
        end
    end

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            gpr_wen   = $urandom_range(0, 1);
            gpr_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            gpr_wdata = $urandom;
            rs1       = ($urandom_range(0, 7) == 0) ? gpr_waddr : 5'($urandom);
            rs2       = 5'($urandom);
            opnd_wen  = $urandom_range(0, 1);
            csr_wen   = $urandom_range(0, 1);
            csr_waddr = pick_csr();
            csr_wdata = $urandom;
            csr_raddr = pick_csr();
            irq       = ($urandom_range(0, 9) == 0);
            irq_no    = 8'($urandom);
            step("rand");
        end
    endtask

    initial begin
        set_idle();
        rs1 = 0; rs2 = 0; csr_raddr = 12'h300;
        reset = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;

        rs1 = 5'd5; rs2 = 5'd31; csr_raddr = 12'h300;
        step("reset_state");

        gpr_wen = 1; gpr_waddr = 5'd5; gpr_wdata = 32'hDEAD_BEEF;
        step("wr_x5");
        set_idle(); rs1 = 5'd5;
        step("rd_x5");
        gpr_wen = 1; gpr_waddr = 5'd0; gpr_wdata = 32'h1234; rs2 = 5'd0;
        step("wr_x0");
        set_idle();
        step("rd_x0");
        gpr_wen = 1; gpr_waddr = 5'd5; gpr_wdata = 32'h1; rs1 = 5'd5;
        step("no_bypass");
        set_idle();
        gpr_wen = 1; gpr_waddr = 5'd9; gpr_wdata = 32'hA5A5_0001;
        step("wr_x9");
        set_idle(); opnd_wen = 1; rs1 = 5'd9; rs2 = 5'd5;
        step("opnd_load");
        opnd_wen = 0; rs1 = 5'd5; rs2 = 5'd9;
        step("opnd_hold1");
        step("opnd_hold2");

        csr_wen = 1; csr_waddr = 12'h305; csr_wdata = 32'h8000_0100; csr_raddr = 12'h305;
        step("wr_mtvec");
        set_idle();
        step("rd_mtvec");
        csr_wen = 1; csr_waddr = 12'h7C0; csr_wdata = 32'd5; csr_raddr = 12'h7C0;
        step("wr_unmapped");
        set_idle();
        step("rd_unmapped");

        irq = 1; irq_no = 8'd11; csr_wdata = 32'h8000_0040;
        csr_wen = 1; csr_waddr = 12'h305;
        step("trap");
        set_idle(); csr_raddr = 12'h342;
        step("rd_mcause");
        csr_raddr = 12'h341;
        step("rd_mepc");
        csr_raddr = 12'h305;
        step("rd_mtvec_after_trap");
        csr_raddr = 12'hF12;
        step("rd_marchid");

        rand_cycles(600);

        // Asynchronous reset between edges with writes pending.
        set_idle();
        gpr_wen = 1; gpr_waddr = 5'd7; gpr_wdata = 32'hCAFE_F00D;
        csr_wen = 1; csr_waddr = 12'h305; csr_wdata = 32'h1234_5678;
        rs1 = 5'd5; rs2 = 5'd9; csr_raddr = 12'h300;
        #2 reset = 1;
        m_reset();
        push_exp("async_reset");
        @(posedge clk);
        #1 reset = 0;
        set_idle();
        rs1 = 5'd7; rs2 = 5'd5; csr_raddr = 12'h305;
        step("after_reset");
        csr_raddr = 12'hF12;
        step("after_reset_id");

        rand_cycles(200);

        @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
